i2s_codec_if: RTL and testbench
===============================

Name: i2s_codec_if

Overview:
- Single-clock I2S master for the on-board audio codec; takes over the bclk/lrclk/serial-data logic currently written inline at system top.
- Upstream: the AV controller supplies 16-bit left/right playback samples through a valid/ready handshake.
- Downstream: captured ADC samples return as a one-cycle strobe that feeds the AV controller audio input.
- A small register slave on the CPU bus replaces the GPIO enable bits.

Parameters:
- BCLK_DIV, 4, clk_i cycles per bclk period; even, ≥2.
- SLOT_BITS, 32, bclk periods per channel slot; frame = 2*SLOT_BITS.
- SAMPLE_BITS, 16, sample width; ≤ SLOT_BITS-1.

Ports:
- clk_i  in  1  system/audio clock
- rst_i  in  1  synchronous active-high reset
- cs_i  in  1  register select
- cyc_i  in  1  bus cycle
- stb_i  in  1  bus strobe
- ack_o  out  1  bus acknowledge
- we_i  in  1  write enable
- adr_i  in  2  register word address
- dat_i  in  16  write data
- dat_o  out  16  read data
- tx_left_i  in  16  playback left sample
- tx_right_i  in  16  playback right sample
- tx_valid_i  in  1  playback sample pair valid
- tx_ready_o  out  1  holding register empty
- rx_left_o  out  16  captured left sample
- rx_right_o  out  16  captured right sample
- rx_valid_o  out  1  one-cycle capture strobe
- bclk_o  out  1  bit clock
- lrclk_o  out  1  word select; 0 = left
- clk_oe_o  out  1  drive enable for bclk/lrclk pads
- sdata_o  out  1  DAC serial data
- sdata_i  in  1  ADC serial data

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: all outputs 0 except tx_ready_o=1. CTRL=0, STATUS=0, all counters 0, all shift and holding registers 0.
- Registers, adr 0 CTRL (R/W):
  - [0] rx_en, [1] tx_en.
  - Write with [15]=1 clears STATUS; bit 15 is not stored.
- Registers, adr 1 STATUS (R):
  - [0] underrun, sticky.
  - [1] frame_toggle: flips at each frame boundary.
- Registers, adr 2/3: read 0; writes ignored.
- Bus timing: ack_o rises 1 cycle after cs&cyc&stb, falls the cycle after stb drops. Writes take effect on the ack cycle. dat_o is valid while ack_o=1.
- Running condition: run = rx_en|tx_en. clk_oe_o = run.
- Counters:
  - While !run, div_cnt and bit_cnt are held at 0 and bclk_o=lrclk_o=0.
  - While run, div_cnt counts 0..BCLK_DIV-1 and wraps.
  - bit_cnt (0..2*SLOT_BITS-1) increments at div_cnt wrap and wraps to 0.
- bclk_o = (div_cnt ≥ BCLK_DIV/2), registered. Data changes on bclk falling edge (div_cnt=0); data is sampled on rising edge (div_cnt=BCLK_DIV/2).
- lrclk_o = (bit_cnt ≥ SLOT_BITS). The MSB of each channel appears one bclk after the lrclk transition (standard I2S).
  - Left bits occupy bit_cnt 1..SAMPLE_BITS.
  - Right bits occupy SLOT_BITS+1..SLOT_BITS+SAMPLE_BITS.
  - All other slot bits transmit 0.
- TX handshake:
  - A sample pair is accepted into the holding register when tx_valid_i&tx_ready_o. tx_ready_o then goes 0 on the next cycle.
  - Frame boundary = bit_cnt wrapping to 0. At the boundary the holding register loads the TX shift register and tx_ready_o returns to 1.
  - If nothing was accepted since the previous boundary, the last pair is repeated and underrun is set (only when tx_en=1).
- Simultaneous accept and boundary in one cycle: the new pair loads the shift register directly, tx_ready_o stays 1, and no underrun is flagged.
- TX disabled: sdata_o=0. The holding register still accepts one pair.
- RX:
  - sdata_i is shifted on rising-edge samples in bit windows 1..SAMPLE_BITS and SLOT_BITS+1..SLOT_BITS+SAMPLE_BITS.
  - After the last right bit is sampled, rx_left_o/rx_right_o update and rx_valid_o pulses for exactly one cycle (only if rx_en).
  - rx_left_o/rx_right_o hold between pulses.
- Disabling both enables mid-frame: takes effect the cycle after the write ack; counters return to 0, and a partial RX frame is discarded with no pulse. The holding register contents are retained.
- rst_i mid-frame: full return to reset values on the next edge.

Decomposition:
- Package i2s_pkg: register addresses (CTRL=0, STATUS=1), CTRL/STATUS bit indices, CLR bit 15.
- Sub-module i2s_clkgen: div_cnt/bit_cnt, bclk_o/lrclk_o, and single-cycle fall_en/rise_en/frame_en pulses.
- Top module: bus slave, TX holding and shift logic, RX shift logic.

Test Plan:
- Reset, then write CTRL=3 → clk_oe_o=1; bclk period 4 clk_i cycles; lrclk period 256 cycles.
- Load tx_left=16'hA5C3, tx_right=16'h0001 before boundary → sdata_o shows A5C3 MSB-first at bit_cnt 1..16, then zeros; right slot shows 0x0001 at bits 33..48.
- Loop sdata_o to sdata_i with tx=(16'h1234,16'hFEDC) → one rx_valid_o pulse per frame, rx_left_o=1234, rx_right_o=FEDC.
- No tx_valid for one full frame → previous pair repeated; STATUS[0]=1. Write CTRL=16'h8003 → STATUS[0]=0.
- Assert tx_valid_i in the exact boundary cycle → pair transmitted in that frame, tx_ready_o stays 1, no underrun.
- Write CTRL=0 at bit_cnt=20 → bclk_o=lrclk_o=clk_oe_o=0 and no rx_valid_o. Re-enable → first lrclk fall aligned to bit_cnt=0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared register map, bit positions and register layouts for the I2S codec interface.
package i2s_pkg;

  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;

  localparam int CTRL_RX_EN     = 0;
  localparam int CTRL_TX_EN     = 1;
  localparam int CTRL_CLR       = 15;
  localparam int STAT_UNDERRUN  = 0;
  localparam int STAT_FRAME_TGL = 1;

  typedef struct packed {
    logic tx_en;
    logic rx_en;
  } ctrl_t;

  typedef struct packed {
    logic frame_tgl;
    logic underrun;
  } status_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock / word-select generator: divider and bit counters plus the edge and
// frame strobes that pace the TX and RX shifters.
module i2s_clkgen #(
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_BITS = 32,
  parameter int BW        = $clog2(2 * SLOT_BITS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          run_i,
  output logic [BW-1:0] bit_cnt_o,
  output logic          bclk_o,
  output logic          lrclk_o,
  output logic          fall_en_o,
  output logic          rise_en_o,
  output logic          frame_en_o
);

  localparam int DW   = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int HALF = BCLK_DIV / 2;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;
  logic          div_wrap_s, bit_wrap_s;

  // Counter advance; everything collapses to zero whenever run drops.
  always_comb begin
    div_wrap_s = (div_cnt_q == DW'(BCLK_DIV - 1));
    bit_wrap_s = (bit_cnt_q == BW'(2 * SLOT_BITS - 1));
    div_cnt_d  = '0;
    bit_cnt_d  = '0;
    if (run_i) begin
      if (div_wrap_s) begin
        div_cnt_d = '0;
        bit_cnt_d = bit_wrap_s ? '0 : bit_cnt_q + BW'(1);
      end else begin
        div_cnt_d = div_cnt_q + DW'(1);
        bit_cnt_d = bit_cnt_q;
      end
    end else begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
    end
    bclk_d  = (div_cnt_d >= DW'(HALF));
    lrclk_d = (bit_cnt_d >= BW'(SLOT_BITS));
  end

  // Counter and pin registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
    end
  end

  // fall_en marks the last cycle of a bit, so data registered on it appears with the next bit.
  assign fall_en_o  = run_i & div_wrap_s;
  assign rise_en_o  = run_i & (div_cnt_q == DW'(HALF));
  assign frame_en_o = run_i & div_wrap_s & bit_wrap_s;
  assign bit_cnt_o  = bit_cnt_q;
  assign bclk_o     = bclk_q;
  assign lrclk_o    = lrclk_q;

endmodule

// File: rtl/i2s_codec_if.sv
// I2S master for the on-board codec: register slave, TX holding/shift path and
// RX capture path around the shared bit-clock generator.
module i2s_codec_if
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV    = 4,
  parameter int SLOT_BITS   = 32,
  parameter int SAMPLE_BITS = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cs_i,
  input  logic                   cyc_i,
  input  logic                   stb_i,
  output logic                   ack_o,
  input  logic                   we_i,
  input  logic [1:0]             adr_i,
  input  logic [15:0]            dat_i,
  output logic [15:0]            dat_o,
  input  logic [SAMPLE_BITS-1:0] tx_left_i,
  input  logic [SAMPLE_BITS-1:0] tx_right_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  output logic [SAMPLE_BITS-1:0] rx_left_o,
  output logic [SAMPLE_BITS-1:0] rx_right_o,
  output logic                   rx_valid_o,
  output logic                   bclk_o,
  output logic                   lrclk_o,
  output logic                   clk_oe_o,
  output logic                   sdata_o,
  input  logic                   sdata_i
);

  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam int PW = 2 * SAMPLE_BITS;

  ctrl_t                  ctrl_q, ctrl_d;
  status_t                status_q, status_d;
  logic                   ack_q, ack_d;
  logic [15:0]            dat_q, dat_d;
  logic                   clk_oe_q, clk_oe_d;
  logic [PW-1:0]          hold_q, hold_d;
  logic [PW-1:0]          tx_sr_q, tx_sr_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   sdata_q, sdata_d;
  logic [PW-1:0]          rx_sr_q, rx_sr_d;
  logic [SAMPLE_BITS-1:0] rx_left_q, rx_left_d;
  logic [SAMPLE_BITS-1:0] rx_right_q, rx_right_d;
  logic                   rx_valid_q, rx_valid_d;

  logic          req_s, wr_s, clr_s, run_s, accept_s, underrun_set_s, next_in_win_s;
  logic [PW-1:0] pair_s;
  logic [BW-1:0] bit_cnt_s;
  logic          bclk_s, lrclk_s, fall_en_s, rise_en_s, frame_en_s;
  logic          unused_s;

  function automatic logic in_window(input int b);
    return ((b >= 1) && (b <= SAMPLE_BITS)) ||
           ((b >= SLOT_BITS + 1) && (b <= SLOT_BITS + SAMPLE_BITS));
  endfunction

  assign unused_s = ^dat_i[14:2];
  assign pair_s   = {tx_left_i, tx_right_i};
  assign accept_s = tx_valid_i & tx_ready_q;
  // Counters only advance while run holds both before and after this edge, so a
  // disable clears them in the same cycle that clk_oe_o drops.
  assign run_s    = (ctrl_q.rx_en | ctrl_q.tx_en) & (ctrl_d.rx_en | ctrl_d.tx_en);

  i2s_clkgen #(
    .BCLK_DIV  (BCLK_DIV),
    .SLOT_BITS (SLOT_BITS),
    .BW        (BW)
  ) u_clkgen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .run_i      (run_s),
    .bit_cnt_o  (bit_cnt_s),
    .bclk_o     (bclk_s),
    .lrclk_o    (lrclk_s),
    .fall_en_o  (fall_en_s),
    .rise_en_o  (rise_en_s),
    .frame_en_o (frame_en_s)
  );

  // Register slave: ack follows the request by one cycle, writes land on the ack cycle.
  always_comb begin
    req_s    = cs_i & cyc_i & stb_i;
    wr_s     = req_s & ack_q & we_i;
    ack_d    = req_s;
    ctrl_d   = ctrl_q;
    clr_s    = 1'b0;
    dat_d    = 16'h0000;
    clk_oe_d = 1'b0;
    if (wr_s && (adr_i == ADR_CTRL)) begin
      ctrl_d.rx_en = dat_i[CTRL_RX_EN];
      ctrl_d.tx_en = dat_i[CTRL_TX_EN];
      clr_s        = dat_i[CTRL_CLR];
    end else begin
      ctrl_d = ctrl_q;
    end
    if (req_s && !we_i) begin
      case (adr_i)
        ADR_CTRL: begin
          dat_d[CTRL_RX_EN] = ctrl_q.rx_en;
          dat_d[CTRL_TX_EN] = ctrl_q.tx_en;
        end
        ADR_STATUS: begin
          dat_d[STAT_UNDERRUN]  = status_q.underrun;
          dat_d[STAT_FRAME_TGL] = status_q.frame_tgl;
        end
        default: dat_d = 16'h0000;
      endcase
    end else begin
      dat_d = 16'h0000;
    end
    clk_oe_d = ctrl_d.rx_en | ctrl_d.tx_en;
  end

  // TX path: holding register, frame-boundary reload and MSB-first serialiser.
  always_comb begin
    hold_d         = accept_s ? pair_s : hold_q;
    next_in_win_s  = in_window(int'(bit_cnt_s) + 1);
    underrun_set_s = 1'b0;
    if (frame_en_s) begin
      tx_ready_d = 1'b1;
    end else if (accept_s) begin
      tx_ready_d = 1'b0;
    end else begin
      tx_ready_d = tx_ready_q;
    end
    if (!run_s) begin
      tx_sr_d = '0;
    end else if (frame_en_s) begin
      tx_sr_d        = accept_s ? pair_s : hold_q;
      underrun_set_s = ~accept_s & tx_ready_q & ctrl_q.tx_en;
    end else if (fall_en_s && next_in_win_s) begin
      tx_sr_d = tx_sr_q << 1;
    end else begin
      tx_sr_d = tx_sr_q;
    end
    if (!run_s || !ctrl_d.tx_en || frame_en_s) begin
      sdata_d = 1'b0;
    end else if (fall_en_s) begin
      sdata_d = next_in_win_s ? tx_sr_q[PW-1] : 1'b0;
    end else begin
      sdata_d = sdata_q;
    end
  end

  // RX path: shift on rising-edge samples, publish after the last right-channel bit.
  always_comb begin
    rx_sr_d    = rx_sr_q;
    rx_left_d  = rx_left_q;
    rx_right_d = rx_right_q;
    rx_valid_d = 1'b0;
    if (rise_en_s && in_window(int'(bit_cnt_s))) begin
      rx_sr_d = {rx_sr_q[PW-2:0], sdata_i};
      if ((bit_cnt_s == BW'(SLOT_BITS + SAMPLE_BITS)) && ctrl_q.rx_en) begin
        rx_left_d  = rx_sr_d[PW-1:SAMPLE_BITS];
        rx_right_d = rx_sr_d[SAMPLE_BITS-1:0];
        rx_valid_d = 1'b1;
      end else begin
        rx_valid_d = 1'b0;
      end
    end else begin
      rx_sr_d = rx_sr_q;
    end
  end

  // STATUS update; a set in the same cycle as a clear wins.
  always_comb begin
    status_d = clr_s ? '0 : status_q;
    if (frame_en_s) begin
      status_d.frame_tgl = ~status_d.frame_tgl;
    end else begin
      status_d.frame_tgl = status_d.frame_tgl;
    end
    if (underrun_set_s) begin
      status_d.underrun = 1'b1;
    end else begin
      status_d.underrun = status_d.underrun;
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q     <= '0;
      status_q   <= '0;
      ack_q      <= 1'b0;
      dat_q      <= 16'h0000;
      clk_oe_q   <= 1'b0;
      hold_q     <= '0;
      tx_sr_q    <= '0;
      tx_ready_q <= 1'b1;
      sdata_q    <= 1'b0;
      rx_sr_q    <= '0;
      rx_left_q  <= '0;
      rx_right_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      status_q   <= status_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      clk_oe_q   <= clk_oe_d;
      hold_q     <= hold_d;
      tx_sr_q    <= tx_sr_d;
      tx_ready_q <= tx_ready_d;
      sdata_q    <= sdata_d;
      rx_sr_q    <= rx_sr_d;
      rx_left_q  <= rx_left_d;
      rx_right_q <= rx_right_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign ack_o      = ack_q;
  assign dat_o      = dat_q;
  assign clk_oe_o   = clk_oe_q;
  assign tx_ready_o = tx_ready_q;
  assign sdata_o    = sdata_q;
  assign rx_left_o  = rx_left_q;
  assign rx_right_o = rx_right_q;
  assign rx_valid_o = rx_valid_q;
  assign bclk_o     = bclk_s;
  assign lrclk_o    = lrclk_s;

endmodule

// File: tb/tb_i2s_codec_if.sv
// Directed bench for i2s_codec_if: timing, TX framing, loopback RX, underrun,
// boundary accept, mid-frame disable and reset.
module tb_i2s_codec_if;

  logic        clk_i = 1'b0;
  logic        rst_i, cs_i, cyc_i, stb_i, we_i, tx_valid_i, loop_en;
  logic [1:0]  adr_i;
  logic [15:0] dat_i, tx_left_i, tx_right_i;
  logic        ack_o, tx_ready_o, rx_valid_o, bclk_o, lrclk_o, clk_oe_o, sdata_o;
  logic [15:0] dat_o, rx_left_o, rx_right_o;
  wire         sdata_i = loop_en & sdata_o;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;
  int k0       = 0;
  int wr_k     = 0;
  int rx_cnt   = 0;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (rx_valid_o) rx_cnt <= rx_cnt + 1;

  i2s_codec_if dut (
    .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i), .cyc_i(cyc_i), .stb_i(stb_i),
    .ack_o(ack_o), .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .tx_left_i(tx_left_i), .tx_right_i(tx_right_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .rx_left_o(rx_left_o), .rx_right_o(rx_right_o),
    .rx_valid_o(rx_valid_o), .bclk_o(bclk_o), .lrclk_o(lrclk_o),
    .clk_oe_o(clk_oe_o), .sdata_o(sdata_o), .sdata_i(sdata_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (p=%0d)", tag, obs, exp, k - k0);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    k++;
  endtask

  task automatic goto(input int p);
    while (k - k0 < p) tick();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = d;
    tick();
    tick();
    wr_k = k;
    cs_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    tick();
  endtask

  task automatic bus_rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
    cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = a;
    tick();
    check_eq({tag, "_ack"}, {31'd0, ack_o}, 32'd1);
    check_eq(tag, {16'd0, dat_o}, {16'd0, exp});
    cs_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
    tick();
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    tx_left_i = l; tx_right_i = r; tx_valid_i = 1'b1;
    for (int i = 0; i < 8 && tx_ready_o; i++) tick();
    tx_valid_i = 1'b0;
    check_eq("tx_accept_ready_low", {31'd0, tx_ready_o}, 32'd0);
  endtask

  task automatic check_rx(input string tag, input logic [15:0] l, input logic [15:0] r);
    check_eq({tag, "_left"}, {16'd0, rx_left_o}, {16'd0, l});
    check_eq({tag, "_right"}, {16'd0, rx_right_o}, {16'd0, r});
  endtask

  initial begin
    logic [15:0] word;
    logic        zacc;
    logic [3:0]  idle_acc;
    int          snap;

    rst_i = 1'b1; cs_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    adr_i = 2'd0; dat_i = 16'h0000; tx_left_i = 16'h0000; tx_right_i = 16'h0000;
    tx_valid_i = 1'b0; loop_en = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();

    check_eq("rst_pins", {28'd0, bclk_o, lrclk_o, clk_oe_o, sdata_o}, 32'd0);
    check_eq("rst_bus", {15'd0, ack_o, dat_o}, 32'd0);
    check_eq("rst_tx_ready", {31'd0, tx_ready_o}, 32'd1);
    check_eq("rst_rx", {rx_left_o, rx_right_o}, 32'd0);
    check_eq("rst_rx_valid", {31'd0, rx_valid_o}, 32'd0);
    bus_rd("rst_status", 2'd1, 16'h0000);
    bus_rd("rst_ctrl", 2'd0, 16'h0000);

    // Enable both directions; p=0 is the first cycle with clk_oe_o high.
    bus_wr(2'd0, 16'h0003);
    k0 = wr_k;
    check_eq("en_clk_oe", {31'd0, clk_oe_o}, 32'd1);
    check_eq("bclk_p1", {31'd0, bclk_o}, 32'd0);
    goto(2); check_eq("bclk_p2", {31'd0, bclk_o}, 32'd1);
    goto(3); check_eq("bclk_p3", {31'd0, bclk_o}, 32'd1);
    goto(4); check_eq("bclk_p4", {31'd0, bclk_o}, 32'd0);
    goto(5); push(16'hA5C3, 16'h0001);
    goto(127); check_eq("lrclk_p127", {31'd0, lrclk_o}, 32'd0);
    goto(128); check_eq("lrclk_p128", {31'd0, lrclk_o}, 32'd1);
    goto(250); check_eq("ready_full", {31'd0, tx_ready_o}, 32'd0);
    goto(255); check_eq("lrclk_p255", {31'd0, lrclk_o}, 32'd1);
    goto(256);
    check_eq("lrclk_p256", {31'd0, lrclk_o}, 32'd0);
    check_eq("ready_after_boundary", {31'd0, tx_ready_o}, 32'd1);
    snap = rx_cnt;

    // Frame 1 carries A5C3/0001; sample each bit mid-bit.
    word = 16'h0000; zacc = 1'b0;
    goto(257); zacc = zacc | sdata_o;
    for (int n = 1; n <= 16; n++) begin
      goto(256 + 4 * n + 1); word = {word[14:0], sdata_o};
    end
    check_eq("tx_left_bits", {16'd0, word}, 32'h0000A5C3);
    for (int n = 17; n <= 32; n++) begin
      goto(256 + 4 * n + 1); zacc = zacc | sdata_o;
    end
    check_eq("tx_pad_bits", {31'd0, zacc}, 32'd0);
    word = 16'h0000;
    for (int n = 33; n <= 48; n++) begin
      goto(256 + 4 * n + 1); word = {word[14:0], sdata_o};
    end
    check_eq("tx_right_bits", {16'd0, word}, 32'h00000001);
    goto(450); check_eq("rx_valid_p450", {31'd0, rx_valid_o}, 32'd0);
    goto(451); check_eq("rx_valid_p451", {31'd0, rx_valid_o}, 32'd1);
    goto(452); check_eq("rx_valid_p452", {31'd0, rx_valid_o}, 32'd0);
    goto(453); push(16'h1234, 16'hFEDC);
    goto(460); check_rx("rx_f1", 16'hA5C3, 16'h0001);
    goto(470); bus_rd("status_f1", 2'd1, 16'h0002);
    goto(510); check_eq("rx_pulses_f1", rx_cnt - snap, 32'd1);

    goto(512); snap = rx_cnt;
    goto(600); bus_rd("status_f2", 2'd1, 16'h0000);
    goto(767); check_eq("rx_pulses_f2", rx_cnt - snap, 32'd1);
    goto(768); check_rx("rx_f2", 16'h1234, 16'hFEDC);

    // Frame 3 had no new pair: repeat and underrun.
    goto(770); bus_rd("status_underrun", 2'd1, 16'h0003);
    bus_wr(2'd0, 16'h8003);
    bus_rd("status_cleared", 2'd1, 16'h0000);
    bus_rd("ctrl_readback", 2'd0, 16'h0003);
    goto(1000); check_rx("rx_f3_repeat", 16'h1234, 16'hFEDC);

    // Offer a pair only in the boundary cycle itself.
    goto(1023);
    tx_left_i = 16'h5A5A; tx_right_i = 16'h0F0F; tx_valid_i = 1'b1;
    tick();
    tx_valid_i = 1'b0;
    check_eq("boundary_ready", {31'd0, tx_ready_o}, 32'd1);
    goto(1030); bus_rd("status_boundary", 2'd1, 16'h0002);
    goto(1230); check_rx("rx_f4_boundary", 16'h5A5A, 16'h0F0F);
    goto(1232); push(16'h1111, 16'h2222);
    goto(1290); push(16'h3333, 16'h4444);

    // Disable at bit 20 of frame 5.
    goto(1360);
    snap = rx_cnt;
    bus_wr(2'd0, 16'h0000);
    check_eq("dis_pins", {29'd0, clk_oe_o, bclk_o, lrclk_o}, 32'd0);
    check_eq("dis_ready_held", {31'd0, tx_ready_o}, 32'd0);
    idle_acc = 4'h0;
    for (int i = 0; i < 300; i++) begin
      tick();
      idle_acc = idle_acc | {bclk_o, lrclk_o, clk_oe_o, sdata_o};
    end
    check_eq("dis_idle_pins", {28'd0, idle_acc}, 32'd0);
    check_eq("dis_no_rx_pulse", rx_cnt - snap, 32'd0);

    // Re-enable: fresh frame from bit 0, retained pair goes out in frame 1.
    bus_wr(2'd0, 16'h0003);
    k0 = wr_k;
    goto(127); check_eq("re_lrclk_p127", {31'd0, lrclk_o}, 32'd0);
    goto(128); check_eq("re_lrclk_p128", {31'd0, lrclk_o}, 32'd1);
    goto(255); check_eq("re_lrclk_p255", {31'd0, lrclk_o}, 32'd1);
    goto(256); check_eq("re_lrclk_p256", {31'd0, lrclk_o}, 32'd0);
    goto(460); check_rx("rx_retained", 16'h3333, 16'h4444);
    goto(462); bus_rd("status_reenable", 2'd1, 16'h0002);

    // Reset mid-frame.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_eq("mrst_pins", {29'd0, clk_oe_o, bclk_o, lrclk_o}, 32'd0);
    check_eq("mrst_ready", {31'd0, tx_ready_o}, 32'd1);
    check_rx("mrst_rx", 16'h0000, 16'h0000);
    tick();
    bus_rd("mrst_status", 2'd1, 16'h0000);
    bus_rd("mrst_ctrl", 2'd0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
